// File: rtl/row_packer_if.sv
// row_packer_if: pixel-stream input and packed-row output of row_packer.
//
// Signals
//   s_valid / s_ready / s_data : one W-bit pixel per handshake (upstream -> packer)
//   m_valid / m_ready / m_data : one packed row per handshake (packer -> pool stage);
//                                m_data[c] is the c-th pixel of the row
//   s_last / err               : only with ROW_PACKER_LAST_EN defined
//
// Handshake: a beat moves on a rising clk edge where valid && ready are both 1.
// A producer that raises valid keeps it and its data stable until that edge;
// ready never depends combinationally on valid on either side of this block.
//
// Modports: slave = the packer's view, master = the upstream/downstream
// environment's view.

interface row_packer_if #(
    parameter int R = 10,
    parameter int W = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [W-1:0]          s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [R-1:0][W-1:0]   m_data;
`ifdef ROW_PACKER_LAST_EN
    logic                  s_last;
    logic                  err;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, err
    );
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, err
    );
`else
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
`endif
endinterface

// File: rtl/row_packer.sv
// row_packer: packs a serial pixel stream into R-pixel row words for the
// 2x2 max-pool stage. Two ping-pong row buffers let the next row fill while
// the previous one waits for the consumer.
//
// Ports
//   clk  : clock, all state on rising edge
//   rstn : asynchronous active-low reset
//   bus  : row_packer_if.slave (pixel input stream, packed row output)
//
// Optional feature (macro ROW_PACKER_LAST_EN): adds s_last framing on the
// input and a sticky err flag. A short row (s_last before the last column)
// is zero-filled and completed at once; a full-length row without s_last
// still completes. Both cases set err, which only rstn clears.

module row_packer #(
    parameter int R = 10,
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rstn,
    row_packer_if.slave bus
);
    localparam int CW = (R > 2) ? $clog2(R) : 1;

    logic [1:0][R-1:0][W-1:0] row_buf;
    logic [CW-1:0]            col;
    logic [1:0]               occ;
    logic [1:0]               occ_next;
    logic                     wr_sel;
    logic                     rd_sel;
    logic                     accept;
    logic                     at_end;
    logic                     complete;
    logic                     xfer;

    assign accept = bus.s_valid && bus.s_ready;
    assign at_end = (col == CW'(R - 1));
    assign xfer   = bus.m_valid && bus.m_ready;

`ifdef ROW_PACKER_LAST_EN
    logic err_q;

    // An early s_last closes the row just like reaching the last column.
    assign complete = accept && (at_end || bus.s_last);
    assign bus.err  = err_q;
`else
    assign complete = accept && at_end;
`endif

    // Ready comes only from registered occupancy so the upstream path has
    // no combinational loop through s_valid or m_ready.
    assign bus.s_ready = rstn && (occ < 2'd2);
    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = row_buf[rd_sel];

    // Completion and transfer in the same cycle cancel out, keeping the
    // pipe full with no bubble.
    always_comb begin
        occ_next = occ;
        if (complete && !xfer) begin
            occ_next = occ + 2'd1;
        end else if (!complete && xfer) begin
            occ_next = occ - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col    <= '0;
            occ    <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            occ <= occ_next;
            if (complete) begin
                col    <= '0;
                wr_sel <= ~wr_sel;
            end else if (accept) begin
                col <= col + CW'(1);
            end
            if (xfer) begin
                rd_sel <= ~rd_sel;
            end
        end
    end

    // While occ > 0 the fill buffer differs from the read buffer, and when
    // occ == 2 nothing is accepted, so the buffer behind m_data never
    // changes while a row is being offered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_buf <= '0;
        end else if (accept) begin
            for (int c = 0; c < R; c++) begin
                if (CW'(c) == col) begin
                    row_buf[wr_sel][c] <= bus.s_data;
                end
`ifdef ROW_PACKER_LAST_EN
                else if (bus.s_last && (CW'(c) > col)) begin
                    row_buf[wr_sel][c] <= '0;
                end
`endif
            end
        end
    end

`ifdef ROW_PACKER_LAST_EN
    // Framing error: s_last disagrees with the column count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (accept && (bus.s_last != at_end)) begin
            err_q <= 1'b1;
        end
    end
`endif

    occ_range_a: assert property (@(posedge clk) disable iff (!rstn) occ != 2'd3);

endmodule
